// File: rtl/uart_receiver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : uart_receiver                                                |
// | Brief   : 8N1 UART receiver with 2-flop synchronizer, mid-bit sampling |
// |           and a first-word-fall-through byte FIFO. Define              |
// |           UART_RX_PARITY_EN to add an even-parity bit to the frame.    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 8
) (
  input  logic                     sysclk,
  input  logic                     cpu_resetn,
  input  logic                     uart_rx,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     parity_err
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_occ_w = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_half_cnt = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_occ_w-1:0] c_occ_one  = c_occ_w'(1);
  localparam logic [c_occ_w-1:0] c_depth    = c_occ_w'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               w_rxs;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               w_push;
  logic               w_frame_err;
  logic               w_overrun;
  logic               r_frame_err;
  logic               r_overrun;

`ifdef UART_RX_PARITY_EN
  logic               r_par;
  logic               w_par_nxt;
  logic               w_par_ok;
  logic               w_parity_bad;
  logic               r_parity_err;
`endif

  // The line is asynchronous; idle-high reset values avoid a false start.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

`ifdef UART_RX_PARITY_EN
  assign w_par_ok = ~(^{r_shift, r_par});
`endif

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_cnt_one;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt    = r_par;
    w_parity_bad = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects short glitches on the line.
        if (r_cnt == c_half_cnt) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == c_last_cnt) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == c_last_cnt) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rxs;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == c_last_cnt) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_frame_err = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end else begin
`ifdef UART_RX_PARITY_EN
            if (w_par_ok) begin
              w_push = 1'b1;
            end else begin
              w_parity_bad = 1'b1;
            end
`else
            w_push = 1'b1;
`endif
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par        <= w_par_nxt;
      r_parity_err <= w_parity_bad;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // FIFO: separate occupancy counter distinguishes full from empty.
  logic [7:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_occ_w-1:0] r_count;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;

  assign w_full    = (r_count == c_depth);
  assign rx_valid  = (r_count != '0);
  assign w_pop     = rx_valid && rx_ready;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_overrun = w_push && w_full && !w_pop;
  assign rx_data   = r_mem[r_rd_ptr];
  assign rx_count  = r_count;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_occ_one;
        2'b01:   r_count <= r_count - c_occ_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_uart_receiver                                             |
// | Brief   : randomized scoreboard bench for uart_receiver (C=16, D=4)    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_uart_receiver;

  localparam int C     = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS    = PAR_EN ? 11 : 10;
  // Line edge to stop-sample cycle: 2 sync cycles, half a bit, then whole bits.
  localparam int STOP_OFS = 2 + C / 2 + (NBITS - 1) * C;

  logic       sysclk = 1'b0;
  logic       cpu_resetn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_receiver #(.CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
    .sysclk    (sysclk),
    .cpu_resetn(cpu_resetn),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 sysclk = ~sysclk;

  typedef enum int {K_GOOD, K_FERR, K_PERR} kind_t;
  typedef struct {
    logic [7:0] data;
    kind_t      kind;
    int         due;
  } frame_t;

  frame_t     pend[$];
  logic [7:0] m_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       exp_perr = 1'b0;
  logic       n_ferr, n_ovr, n_perr, do_pop, do_push;
  frame_t     mon_f;
  int         ready_mode = 0;
  int         ready_pulse_cyc = -1;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue plus frames scheduled to land at their stop sample.
  always @(negedge sysclk) begin
    if (!cpu_resetn) begin
      m_q.delete();
      pend.delete();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      exp_perr = 1'b0;
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 0);
      check("rst_count", rx_count, 0);
      check("rst_flags", {frame_err, overrun, parity_err}, 3'b000);
    end else begin
      check("valid", rx_valid, m_q.size() > 0);
      check("count", rx_count, m_q.size());
      check("frame_err", frame_err, exp_ferr);
      check("overrun", overrun, exp_ovr);
      check("parity_err", parity_err, exp_perr);
      do_pop  = (m_q.size() > 0) && rx_ready;
      do_push = 1'b0;
      n_ferr  = 1'b0;
      n_ovr   = 1'b0;
      n_perr  = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mon_f = pend.pop_front();
        case (mon_f.kind)
          K_GOOD: begin
            if (m_q.size() == DEPTH && !do_pop) n_ovr = 1'b1;
            else do_push = 1'b1;
          end
          K_FERR:  n_ferr = 1'b1;
          default: n_perr = 1'b1;
        endcase
      end
      if (do_pop) begin
        check("data", rx_data, m_q[0]);
        void'(m_q.pop_front());
      end
      if (do_push) m_q.push_back(mon_f.data);
      exp_ferr = n_ferr;
      exp_ovr  = n_ovr;
      exp_perr = n_perr;
    end
  end

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        2:       rx_ready = 1'($urandom_range(0, 1));
        default: rx_ready = (cyc == ready_pulse_cyc);
      endcase
    end
  end

  task automatic bit_out(input logic v);
    uart_rx = v;
    repeat (C) @(posedge sysclk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    frame_t f;
    f.data = b;
    f.due  = cyc + STOP_OFS;
    if (!stop_bit) f.kind = K_FERR;
    else if (PAR_EN && par_flip) f.kind = K_PERR;
    else f.kind = K_GOOD;
    pend.push_back(f);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    if (PAR_EN) bit_out((^b) ^ par_flip);
    bit_out(stop_bit);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    ready_mode = 1;
    while (m_q.size() > 0 && n < limit) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    check("drain_done", m_q.size(), 0);
    ready_mode = 0;
    idle(3);
    check("drain_valid", rx_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       bad;
    logic       pf;
    repeat (4) @(posedge sysclk);
    #1;
    cpu_resetn = 1'b1;
    idle(5);

    send(8'hA5, 1'b1, 1'b0);
    check("single_count", rx_count, 1);
    check("single_data", rx_data, 8'hA5);
    idle(10);
    drain(50);

    uart_rx = 1'b0;
    repeat (5) @(posedge sysclk);
    #1;
    idle(40);
    check("glitch_valid", rx_valid, 0);

    send(8'h3C, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (40) @(posedge sysclk);
    #1;
    check("break_count", rx_count, 0);
    idle(10);
    send(8'h11, 1'b1, 1'b0);
    idle(5);
    drain(50);

    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
    idle(10);
    check("ovr_count", rx_count, 4);
    drain(100);

    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 1'b0);
    ready_pulse_cyc = cyc + STOP_OFS;
    ready_mode = 3;
    send(8'h55, 1'b1, 1'b0);
    ready_mode = 0;
    idle(5);
    check("full_count", rx_count, 4);
    drain(100);

    send(8'h9A, 1'b1, 1'b0);
    uart_rx = 1'b0;
    repeat (3 * C) @(posedge sysclk);
    #1;
    cpu_resetn = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    cpu_resetn = 1'b1;
    idle(5);
    check("post_rst_count", rx_count, 0);
    send(8'hC3, 1'b1, 1'b0);
    idle(5);
    drain(50);

    if (PAR_EN) begin
      send(8'h07, 1'b1, 1'b1);
      idle(5);
      check("par_count", rx_count, 0);
      send(8'h07, 1'b1, 1'b0);
      idle(5);
      drain(50);
    end

    ready_mode = 2;
    for (int i = 0; i < 25; i++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      pf  = ($urandom_range(0, 5) == 0);
      send(b, !bad, pf);
      if (bad) idle(5 + $urandom_range(0, 10));
      else idle($urandom_range(0, 12));
    end
    drain(200);
    check("pending_empty", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
